flag_unit: RTL and testbench

- Producer side of the condition-flag interface consumed by branch_cntrl.
- Registers N/Z/V from the execute-stage result, with opcode-dependent update masks.
- Bypasses a same-cycle update to the branch comparator.
- Honours stall, flush and halt; presents flags in the {n,z,v} = flag[2:0] layout branch_cntrl expects.

---
 rtl/flag_unit.sv | 122 ++++++++++++
 tb/tb_flag_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// flag_unit: condition-flag producer for branch_cntrl.
// Holds {n,z,v} from execute-stage results, applying opcode-dependent update masks.
// flag_fwd gives a same-cycle bypass, and a committed HLT freezes the unit until reset.
//
// Commit semantics: the execute-stage instruction is consumed exactly once.
// That happens on the rising edge of a cycle where ex_valid=1, stall=0, flush=0
// and the unit is in RUN. While stall is held, the instruction is simply re-presented.
// flush drops it outright, even when stall is also high.
module flag_unit #(
    parameter int          DW       = 16,
    parameter logic [2:0]  FLAG_RST = 3'b000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] alu_a,
    input  logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_out,
    input  logic          stall,
    input  logic          flush,
    output logic [2:0]    flag_out,
    output logic [2:0]    flag_fwd,
    output logic          flag_upd,
    output logic          halted
);

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_PADDSB = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_AND    = 4'h3;
    localparam logic [3:0] OP_NOR    = 4'h4;
    localparam logic [3:0] OP_SLL    = 4'h5;
    localparam logic [3:0] OP_SRL    = 4'h6;
    localparam logic [3:0] OP_SRA    = 4'h7;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam int MSB = DW - 1;

    // halted is a direct decode of this state register, so the FSM state is always visible.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic            commit;
    logic [2:0]      upd_mask;    // bit order {n,z,v}
    logic [2:0]      flag_new;
    logic [2:0]      flag_nxt;
    logic [DW-2:0]   a_low;
    logic [DW-2:0]   b_low;
    logic            carry_add;
    logic            carry_sub;
    logic            raw_add_msb;
    logic            raw_sub_msb;
    logic            v_add;
    logic            v_sub;

    assign commit = ex_valid & ~stall & ~flush & (state == RUN);
    assign halted = (state == HALT);

    // Opcode-dependent update mask. Opcodes that leave flags alone, including HLT, get an empty mask.
    always_comb begin
        upd_mask = 3'b000;
        case (opcode)
            OP_ADD, OP_SUB:                          upd_mask = 3'b111;
            OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA:  upd_mask = 3'b010;
            OP_PADDSB:                               upd_mask = 3'b000;
            default:                                 upd_mask = 3'b000;
        endcase
    end

    // Overflow is taken from the raw wrapped sum/difference, not the saturated alu_out.
    // Only the raw MSB matters. It equals a^b^carry-into-MSB (with b inverted for SUB).
    // The carry out of the low DW-1 bits is found by a compare instead of a full adder.
    always_comb begin
        a_low       = alu_a[DW-2:0];
        b_low       = alu_b[DW-2:0];
        carry_add   = (a_low > ~b_low);
        carry_sub   = (a_low >= b_low);
        raw_add_msb = alu_a[MSB] ^ alu_b[MSB] ^ carry_add;
        raw_sub_msb = alu_a[MSB] ^ ~alu_b[MSB] ^ carry_sub;
        v_add       = (alu_a[MSB] == alu_b[MSB]) & (raw_add_msb != alu_a[MSB]);
        v_sub       = (alu_a[MSB] != alu_b[MSB]) & (raw_sub_msb != alu_a[MSB]);
        flag_new    = {alu_out[MSB], (alu_out == '0), (opcode == OP_SUB) ? v_sub : v_add};
        flag_nxt    = (flag_out & ~upd_mask) | (flag_new & upd_mask);
        flag_fwd    = commit ? flag_nxt : flag_out;
    end

    // FSM next state: only a committed HLT leaves RUN, and HALT is left only through reset.
    always_comb begin
        state_nxt = state;
        if (commit && (opcode == OP_HLT)) begin
            state_nxt = HALT;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Flag register and the one-cycle update pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_out <= FLAG_RST;
            flag_upd <= 1'b0;
        end else begin
            flag_upd <= commit & (|upd_mask);
            if (commit) begin
                flag_out <= flag_nxt;
            end
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: table-driven directed vectors plus hand-written multi-cycle sequences.
module tb_flag_unit;

    localparam int DW = 16;

    localparam logic [3:0] ADD = 4'h0, PADDSB = 4'h1, SUB = 4'h2, AND_ = 4'h3;
    localparam logic [3:0] NOR = 4'h4, SLL = 4'h5, SRA = 4'h7, LW = 4'h8;
    localparam logic [3:0] SW = 4'h9, LHB = 4'hA, BR = 4'hC, JAL = 4'hD, HLT = 4'hF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ex_valid = 1'b0;
    logic [3:0]    opcode = '0;
    logic [DW-1:0] alu_a = '0;
    logic [DW-1:0] alu_b = '0;
    logic [DW-1:0] alu_out = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [2:0]    flag_out;
    logic [2:0]    flag_fwd;
    logic          flag_upd;
    logic          halted;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_q[$];

    typedef struct {
        logic          ev;
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] r;
        logic          st;
        logic          fl;
        logic [2:0]    fwd;
        logic [2:0]    out;
        logic          upd;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    // clock / reset block
    always #5 clk = ~clk;

    flag_unit #(.DW(DW), .FLAG_RST(3'b000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_valid (ex_valid),
        .opcode   (opcode),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .stall    (stall),
        .flush    (flush),
        .flag_out (flag_out),
        .flag_fwd (flag_fwd),
        .flag_upd (flag_upd),
        .halted   (halted)
    );

    function automatic vec_t mk(input logic ev, input logic [3:0] op,
                                input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [DW-1:0] r, input logic st, input logic fl,
                                input logic [2:0] fwd, input logic [2:0] out, input logic upd);
        vec_t v;
        v.ev = ev; v.op = op; v.a = a; v.b = b; v.r = r;
        v.st = st; v.fl = fl; v.fwd = fwd; v.out = out; v.upd = upd;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got=%b expected=%b", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] r,
                         input logic st, input logic fl);
        ex_valid = ev; opcode = op; alu_a = a; alu_b = b; alu_out = r;
        stall = st; flush = fl;
    endtask

    // Checks bypass mid-cycle, then registered outputs just after the next rising edge.
    task automatic step_check(input string name, input int idx, input logic [2:0] e_fwd,
                              input logic [2:0] e_out, input logic e_upd, input logic e_halt);
        #1;
        check({name, "_fwd"}, idx, flag_fwd, e_fwd);
        exp_q.push_back(e_out);
        @(posedge clk);
        #1;
        check({name, "_out"}, idx, flag_out, exp_q.pop_front());
        check({name, "_upd"}, idx, {2'b00, flag_upd}, {2'b00, e_upd});
        check({name, "_halt"}, idx, {2'b00, halted}, {2'b00, e_halt});
    endtask

    initial begin
        //              ev  op      a        b        r        st  fl  fwd     out     upd
        vecs[0]  = mk(1, ADD,   16'h7FFF, 16'h0001, 16'h7FFF, 0, 0, 3'b001, 3'b001, 1);
        vecs[1]  = mk(1, SUB,   16'h0005, 16'h0005, 16'h0000, 0, 0, 3'b010, 3'b010, 1);
        vecs[2]  = mk(1, AND_,  16'h8001, 16'h8000, 16'h8000, 0, 0, 3'b000, 3'b000, 1);
        vecs[3]  = mk(1, SUB,   16'h8000, 16'h0001, 16'h8000, 0, 0, 3'b101, 3'b101, 1);
        vecs[4]  = mk(1, LW,    16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b101, 3'b101, 0);
        vecs[5]  = mk(1, SW,    16'h1234, 16'h0000, 16'h0000, 0, 0, 3'b101, 3'b101, 0);
        vecs[6]  = mk(1, LHB,   16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b101, 3'b101, 0);
        vecs[7]  = mk(1, BR,    16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b101, 3'b101, 0);
        vecs[8]  = mk(1, PADDSB,16'h7FFF, 16'h7FFF, 16'h0000, 0, 0, 3'b101, 3'b101, 0);
        vecs[9]  = mk(0, ADD,   16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b101, 3'b101, 0);
        vecs[10] = mk(1, NOR,   16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b111, 3'b111, 1);
        vecs[11] = mk(1, ADD,   16'h0000, 16'h0001, 16'h0001, 0, 1, 3'b111, 3'b111, 0);
        vecs[12] = mk(1, ADD,   16'h0000, 16'h0001, 16'h0001, 1, 1, 3'b111, 3'b111, 0);
        vecs[13] = mk(1, ADD,   16'hFFFF, 16'h0001, 16'h0000, 0, 0, 3'b010, 3'b010, 1);
        vecs[14] = mk(1, SRA,   16'hFFFF, 16'h0003, 16'hFFFF, 0, 0, 3'b000, 3'b000, 1);
        vecs[15] = mk(1, SUB,   16'h7FFF, 16'hFFFF, 16'h7FFF, 0, 0, 3'b001, 3'b001, 1);
        vecs[16] = mk(1, ADD,   16'h8000, 16'h8000, 16'h8000, 0, 0, 3'b101, 3'b101, 1);
        vecs[17] = mk(1, SLL,   16'h8000, 16'h0001, 16'h0000, 0, 0, 3'b111, 3'b111, 1);
        vecs[18] = mk(1, JAL,   16'h0000, 16'h0000, 16'h0000, 0, 0, 3'b111, 3'b111, 0);

        // reset state
        #2;
        check("rst_out", 0, flag_out, 3'b000);
        check("rst_fwd", 0, flag_fwd, 3'b000);
        check("rst_upd", 0, {2'b00, flag_upd}, 3'b000);
        check("rst_halt", 0, {2'b00, halted}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].ev, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].st, vecs[i].fl);
            step_check("vec", i, vecs[i].fwd, vecs[i].out, vecs[i].upd, 1'b0);
        end

        // stall held 3 cycles on an ADD yielding Z: flags hold, one commit on release
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, ADD, 16'h0001, 16'hFFFF, 16'h0000, 1, 0);
            step_check("stall", i, 3'b111, 3'b111, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1, ADD, 16'h0001, 16'hFFFF, 16'h0000, 0, 0);
        step_check("stall_rel", 0, 3'b010, 3'b010, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, ADD, 16'h0001, 16'hFFFF, 16'h0000, 0, 0);
        step_check("stall_after", 0, 3'b010, 3'b010, 1'b0, 1'b0);

        // stall+flush held together over two cycles: nothing changes
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1, SUB, 16'h8000, 16'h0001, 16'h8000, 1, 1);
            step_check("stfl", i, 3'b010, 3'b010, 1'b0, 1'b0);
        end

        // bubble with unknown opcode and result must not corrupt flags
        @(negedge clk);
        drive(0, 4'bxxxx, 16'hxxxx, 16'hxxxx, 16'hxxxx, 0, 0);
        step_check("xop", 0, 3'b010, 3'b010, 1'b0, 1'b0);

        // HLT commit: no flag change, halted from the next cycle
        @(negedge clk);
        drive(1, HLT, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        #1;
        check("hlt_pre_halt", 0, {2'b00, halted}, 3'b000);
        step_check("hlt", 0, 3'b010, 3'b010, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1, ADD, 16'h8000, 16'h8000, 16'h0000, 0, 0);
            step_check("halted_add", i, 3'b010, 3'b010, 1'b0, 1'b1);
        end

        // asynchronous reset between edges while halted
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_halt_out", 0, flag_out, 3'b000);
        check("arst_halt_halted", 0, {2'b00, halted}, 3'b000);
        check("arst_halt_upd", 0, {2'b00, flag_upd}, 3'b000);
        @(negedge clk);
        drive(1, ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 0, 0);
        rst_n = 1'b1;
        step_check("post_rst_add", 0, 3'b001, 3'b001, 1'b1, 1'b0);

        // asynchronous reset while a stalled SUB is waiting; it commits after release
        @(negedge clk);
        drive(1, SUB, 16'h0005, 16'h0005, 16'h0000, 1, 0);
        step_check("pre_rst_stall", 0, 3'b001, 3'b001, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stall_out", 0, flag_out, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, SUB, 16'h0005, 16'h0005, 16'h0000, 0, 0);
        step_check("post_rst_sub", 0, 3'b010, 3'b010, 1'b1, 1'b0);

        @(negedge clk);
        drive(0, ADD, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        step_check("final_idle", 0, 3'b010, 3'b010, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
